// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------------------------
// wb_pkg: shared types for the register-file write-back arbiter.
//   WB_DATA_W / WB_ADDR_W : default register data / address widths
//   wb_entry_t            : one pending write (destination + value) at default widths
//   wb_src_e              : which source drives the regfile write port in a given cycle
// ---------------------------------------------------------------------------------------------
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LATE
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------------------------
// wb_fifo: synchronous FIFO of DEPTH entries holding late write-back results.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata: write an entry (ignored when full)
//   pop/rdata : rdata shows the head combinationally; pop advances past it (ignored when empty)
//   full/empty/count : occupancy status
// ---------------------------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------------------------
// regfile_wb_arbiter: merges single-cycle ALU results and buffered late (multi-cycle / load)
// results into one registered register-file write per cycle, and keeps a busy scoreboard of
// destinations whose late result is still outstanding.
//
// Optional feature: define WB_STARVE_GUARD_EN to add a starvation guard. After STARVE_LIMIT
// consecutive cycles in which the ALU wins while late results wait, the FIFO head is written
// instead and o_stall_req pulses so the core re-presents its ALU result next cycle. Without the
// macro the ALU always has priority and o_stall_req is tied low.
//
// Ports:
//   i_clk, i_reset                        clock, asynchronous active-high reset
//   i_alu_valid/_rd_addr/_rd_data         ALU result (never back-pressured)
//   i_late_valid/_rd_addr/_rd_data        late result offer; o_late_ready = FIFO not full
//   i_issue_valid/_rd_addr                late op issued -> destination marked busy
//   o_busy_mask                           bit r set while a late result for xr is outstanding
//   o_late_count                          FIFO occupancy
//   o_stall_req                           hold request from the starvation guard
//   o_rd_addr/o_rd_data/o_rd_wren         registered regfile write port
// ---------------------------------------------------------------------------------------------
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W       = WB_DATA_W,
    parameter int unsigned ADDR_W       = WB_ADDR_W,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_alu_valid,
    input  logic [ADDR_W-1:0]        i_alu_rd_addr,
    input  logic [DATA_W-1:0]        i_alu_rd_data,
    input  logic                     i_late_valid,
    output logic                     o_late_ready,
    input  logic [ADDR_W-1:0]        i_late_rd_addr,
    input  logic [DATA_W-1:0]        i_late_rd_data,
    input  logic                     i_issue_valid,
    input  logic [ADDR_W-1:0]        i_issue_rd_addr,
    output logic [2**ADDR_W-1:0]     o_busy_mask,
    output logic [$clog2(DEPTH):0]   o_late_count,
    output logic                     o_stall_req,
    output logic [ADDR_W-1:0]        o_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_wren
);

    localparam int unsigned NREG = 2**ADDR_W;

    // Entry at this instance's widths (wb_entry_t is the default-width equivalent).
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                  push_entry;
    entry_t                  head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    alu_win;
    logic                    force_late;
    wb_src_e                 sel;
    logic [NREG-1:0]         busy_q;
    logic [NREG-1:0]         busy_d;

    // An ALU write to x0 is treated as no request so the FIFO may drain that cycle.
    assign alu_win = i_alu_valid && (i_alu_rd_addr != '0);

    // Late results for x0 complete the handshake but never occupy an entry.
    assign push         = i_late_valid && !fifo_full && (i_late_rd_addr != '0);
    assign o_late_ready = !fifo_full;
    assign push_entry   = '{addr: i_late_rd_addr, data: i_late_rd_data};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_late_count)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_q;
    logic [SC_W-1:0] starve_d;
    logic            starve_hit;

    assign starve_hit = (starve_q == SC_W'(STARVE_LIMIT));
    // Only an ALU request actually needs to be held back; an idle ALU lets the FIFO drain anyway.
    assign force_late  = starve_hit && alu_win;
    assign o_stall_req = force_late;

    always_comb begin
        starve_d = '0;
        if (!starve_hit && alu_win && !fifo_empty) starve_d = starve_q + SC_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) starve_q <= '0;
        else         starve_q <= starve_d;
    end
`else
    assign force_late  = 1'b0;
    assign o_stall_req = 1'b0;
`endif

    always_comb begin
        sel = SRC_NONE;
        if (alu_win && !force_late) sel = SRC_ALU;
        else if (!fifo_empty)       sel = SRC_LATE;
    end

    assign pop = (sel == SRC_LATE);

    // Address/data only load when a write happens, so they hold during idle cycles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else begin
            o_rd_wren <= (sel != SRC_NONE);
            unique case (sel)
                SRC_ALU: begin
                    o_rd_addr <= i_alu_rd_addr;
                    o_rd_data <= i_alu_rd_data;
                end
                SRC_LATE: begin
                    o_rd_addr <= head.addr;
                    o_rd_data <= head.data;
                end
                default: ;
            endcase
        end
    end

    // Clear first, then set: an issue to the register being retired this edge stays busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head.addr] = 1'b0;
        if (i_issue_valid && (i_issue_rd_addr != '0)) busy_d[i_issue_rd_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign o_busy_mask = busy_q;

    // Decode must stall on a busy destination; reaching here with one is a pipeline bug.
    // Issuing to the register whose late result retires on this very edge is fine.
    a_issue_to_busy: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_issue_valid && (i_issue_rd_addr != '0) && busy_q[i_issue_rd_addr] &&
          !(pop && (head.addr == i_issue_rd_addr))));

    a_alu_to_busy: assert property (@(posedge i_clk) disable iff (i_reset)
        !(alu_win && busy_q[i_alu_rd_addr]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_addr = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              late_valid = 1'b0;
    logic              late_ready;
    logic [ADDR_W-1:0] late_addr = '0;
    logic [DATA_W-1:0] late_data = '0;
    logic              issue_valid = 1'b0;
    logic [ADDR_W-1:0] issue_addr = '0;
    logic [31:0]       busy_mask;
    logic [2:0]        late_count;
    logic              stall_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_wren;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_alu_valid     (alu_valid),
        .i_alu_rd_addr   (alu_addr),
        .i_alu_rd_data   (alu_data),
        .i_late_valid    (late_valid),
        .o_late_ready    (late_ready),
        .i_late_rd_addr  (late_addr),
        .i_late_rd_data  (late_data),
        .i_issue_valid   (issue_valid),
        .i_issue_rd_addr (issue_addr),
        .o_busy_mask     (busy_mask),
        .o_late_count    (late_count),
        .o_stall_req     (stall_req),
        .o_rd_addr       (rd_addr),
        .o_rd_data       (rd_data),
        .o_rd_wren       (rd_wren)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic [31:0]       m_busy;
    logic              m_wren;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_starve;

    always @(posedge clk or posedge rst) begin : model
        int   n;
        bit   alu_ok;
        bit   force_l;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_busy   = '0;
            m_wren   = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_starve = 0;
        end else begin
            n       = mq.size();
            alu_ok  = alu_valid && (alu_addr != 0);
            force_l = 1'b0;
`ifdef WB_STARVE_GUARD_EN
            force_l = alu_ok && (m_starve == STARVE_LIMIT);
            if (m_starve == STARVE_LIMIT)  m_starve = 0;
            else if (alu_ok && n > 0)      m_starve = m_starve + 1;
            else                           m_starve = 0;
`endif
            if (alu_ok && !force_l) begin
                m_wren = 1'b1;
                m_addr = alu_addr;
                m_data = alu_data;
            end else if (n > 0) begin
                e = mq.pop_front();
                m_wren = 1'b1;
                m_addr = e.a;
                m_data = e.d;
                m_busy[e.a] = 1'b0;
            end else begin
                m_wren = 1'b0;
            end
            if (late_valid && n < DEPTH && late_addr != 0) begin
                e.a = late_addr;
                e.d = late_data;
                mq.push_back(e);
            end
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    end

    // Compare process: every cycle outside reset, mid-cycle.
    always @(negedge clk) begin
        logic exp_stall;
        if (!rst) begin
            exp_stall = 1'b0;
`ifdef WB_STARVE_GUARD_EN
            exp_stall = (m_starve == STARVE_LIMIT) && alu_valid && (alu_addr != 0);
`endif
            chk("cyc_wren",  32'(rd_wren),    32'(m_wren));
            chk("cyc_addr",  32'(rd_addr),    32'(m_addr));
            chk("cyc_data",  rd_data,         m_data);
            chk("cyc_busy",  busy_mask,       m_busy);
            chk("cyc_count", 32'(late_count), 32'(mq.size()));
            chk("cyc_ready", 32'(late_ready), 32'(mq.size() < DEPTH));
            chk("cyc_stall", 32'(stall_req),  32'(exp_stall));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        late_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic late(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        late_valid = 1'b1;
        late_addr  = a;
        late_data  = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        issue_valid = 1'b1;
        issue_addr  = a;
    endtask

    initial begin
        int found;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        chk("rst_wren",  32'(rd_wren),    32'd0);
        chk("rst_busy",  busy_mask,       32'd0);
        chk("rst_count", 32'(late_count), 32'd0);
        chk("rst_stall", 32'(stall_req),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(late_ready), 32'd1);

        // ALU only
        alu(5, 32'hDEAD_BEEF);
        cyc();
        chk("alu_wren", 32'(rd_wren), 32'd1);
        chk("alu_addr", 32'(rd_addr), 32'd5);
        chk("alu_data", rd_data,       32'hDEAD_BEEF);
        alu(0, 32'h55);
        cyc();
        chk("alu_x0_wren", 32'(rd_wren), 32'd0);
        chk("alu_x0_hold", 32'(rd_addr), 32'd5);
        idle();

        // Late path: issue, push, write two cycles after push
        issue(7);
        cyc();
        idle();
        chk("late_busy7", busy_mask, 32'h0000_0080);
        late(7, 32'h1234);
        cyc();
        idle();
        chk("late_count1", 32'(late_count), 32'd1);
        chk("late_nowr",   32'(rd_wren),    32'd0);
        cyc();
        chk("late_wren", 32'(rd_wren), 32'd1);
        chk("late_addr", 32'(rd_addr), 32'd7);
        chk("late_data", rd_data,       32'h1234);
        chk("late_clr",  busy_mask,     32'd0);

        // Contention: ALU every cycle, fill FIFO, then drain in order
        alu(1, 32'h100);
        for (int i = 0; i < 4; i++) begin
            late(ADDR_W'(20 + i), 32'hA0 + i);
            cyc();
        end
        chk("full_count", 32'(late_count), 32'd4);
        chk("full_ready", 32'(late_ready), 32'd0);
        chk("full_alu",   32'(rd_addr),    32'd1);
        late(24, 32'hFF);
        cyc();
        chk("full_reject", 32'(late_count), 32'd4);
        idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("drain_addr", 32'(rd_addr), 32'(20 + i));
            chk("drain_data", rd_data,       32'hA0 + i);
        end
        cyc();
        chk("drain_done", 32'(rd_wren), 32'd0);

        // Same-edge issue and retire of x9: set wins
        issue(9);
        cyc();
        idle();
        late(9, 32'h99);
        cyc();
        idle();
        issue(9);
        cyc();
        idle();
        chk("x9_write", 32'(rd_addr), 32'd9);
        chk("x9_busy",  busy_mask,     32'h0000_0200);
        late(9, 32'h999);
        cyc();
        idle();
        cyc();
        chk("x9_data2", rd_data,   32'h999);
        chk("x9_clr",   busy_mask, 32'd0);

        // Late result for x0: accepted, no entry
        late(0, 32'h77);
        #1;
        chk("x0_ready", 32'(late_ready), 32'd1);
        cyc();
        idle();
        chk("x0_count", 32'(late_count), 32'd0);
        chk("x0_nowr",  32'(rd_wren),    32'd0);

        // Same-cycle push and pop
        late(3, 32'h33);
        cyc();
        late(4, 32'h44);
        cyc();
        idle();
        chk("pp_count", 32'(late_count), 32'd1);
        chk("pp_addr",  32'(rd_addr),    32'd3);
        cyc();
        chk("pp_addr2", 32'(rd_addr),    32'd4);
        chk("pp_data2", rd_data,         32'h44);

        // Reset mid-stream: 3 entries queued, x2 and x8 busy
        issue(2);
        cyc();
        issue(8);
        cyc();
        idle();
        chk("pre_busy", busy_mask, 32'h0000_0104);
        alu(1, 32'h1);
        late(2, 32'h22);
        cyc();
        late(8, 32'h88);
        cyc();
        late(3, 32'h333);
        cyc();
        late_valid = 1'b0;
        chk("pre_count", 32'(late_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_wren",  32'(rd_wren),    32'd0);
        chk("mid_rst_addr",  32'(rd_addr),    32'd0);
        chk("mid_rst_data",  rd_data,         32'd0);
        chk("mid_rst_busy",  busy_mask,       32'd0);
        chk("mid_rst_count", 32'(late_count), 32'd0);
        chk("mid_rst_stall", 32'(stall_req),  32'd0);
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_ready", 32'(late_ready), 32'd1);
        cyc();
        chk("post_rst_wren", 32'(rd_wren), 32'd0);

        // Starvation: continuous ALU with one waiting late entry
        alu(1, 32'h5);
        late(4, 32'h4444);
        cyc();
        late_valid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (stall_req) begin
                found = i;
                break;
            end
        end
        chk("starve_cycle", 32'(found), 32'd8);
        cyc();
        chk("starve_addr", 32'(rd_addr), 32'd4);
        chk("starve_data", rd_data,       32'h4444);
        idle();
`else
        found = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (stall_req) found = found + 1;
        end
        chk("nostarve_pulses", 32'(found),      32'd0);
        chk("nostarve_count",  32'(late_count), 32'd1);
        idle();
        cyc();
        chk("nostarve_drain", 32'(rd_addr), 32'd4);
`endif
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
